// File: rtl/csel_sched_pkg.sv
// rtl/csel_sched_pkg.sv - shared types, constants and round-robin pick for the 6-way selector scheduler
package csel_sched_pkg;

  localparam int NUM_PORTS   = 6;
  localparam int IDX_W       = 3;
  localparam int CREDIT_W    = 4;
  localparam int CREDIT_INIT = 4;
  localparam int TIMEOUT     = 255;
  localparam int WD_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [NUM_PORTS-1:0] onehot;
    logic [IDX_W-1:0]     idx;
  } pick_t;

  // First eligible port searching ptr, ptr+1, ... modulo NUM_PORTS.
  function automatic pick_t rr_pick(input logic [NUM_PORTS-1:0] elig,
                                    input logic [IDX_W-1:0]     ptr);
    pick_t       res;
    int unsigned k;
    res = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (!res.valid && elig[k]) begin
        res.valid     = 1'b1;
        res.onehot    = '0;
        res.onehot[k] = 1'b1;
        res.idx       = IDX_W'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/csel_credit_ctr.sv
// rtl/csel_credit_ctr.sv - per-port saturating credit counter with return/consume inputs
module csel_credit_ctr
  import csel_sched_pkg::*;
#(
  parameter int CW    = CREDIT_W,
  parameter int CINIT = CREDIT_INIT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ret_i,
  input  logic          consume_i,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  output logic          nonzero_o
);

  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] CLOAD = CW'(CINIT);

  logic [CW-1:0] count_q;

  // A return that lands on a full counter is dropped and reported; simultaneous
  // return and consume cancel out.
  assign overflow_o = ret_i & ~consume_i & (count_q == CMAX);
  assign nonzero_o  = (count_q != '0);
  assign count_o    = count_q;

  // Credit register: +1 on lone return, -1 on lone consume, held at both bounds.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= CLOAD;
    end else if (ret_i && !consume_i && count_q != CMAX) begin
      count_q <= count_q + 1'b1;
    end else if (consume_i && !ret_i && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/cselector6_sched.sv
// rtl/cselector6_sched.sv - round-robin credit-aware select generator for a 6-way click selector
module cselector6_sched
  import csel_sched_pkg::*;
#(
  parameter int CREDIT_W_P    = CREDIT_W,
  parameter int CREDIT_INIT_P = CREDIT_INIT,
  parameter int TIMEOUT_P     = TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_PORTS-1:0]           i_enable,
  input  logic                           i_fire,
  input  logic [NUM_PORTS-1:0]           i_credit_ret,
  output logic [NUM_PORTS-1:0]           o_select,
  output logic                           o_drive_en,
  output logic [NUM_PORTS*CREDIT_W_P-1:0] o_credit,
  output logic                           o_timeout,
  output logic                           o_cred_err
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_P);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_P - 1);

  state_e                 state_q;
  logic [NUM_PORTS-1:0]   sel_q;
  logic [IDX_W-1:0]       sel_idx_q;
  logic                   drv_q;
  logic [IDX_W-1:0]       rr_q;
  logic [WD_W-1:0]        wd_q;
  logic                   timeout_q;
  logic                   cred_err_q;

  logic [NUM_PORTS-1:0]   nonzero;
  logic [NUM_PORTS-1:0]   ovf;
  logic [NUM_PORTS-1:0]   elig;
  logic [NUM_PORTS-1:0]   consume;
  logic                   fire_acc;
  logic [IDX_W-1:0]       rr_next;
  pick_t                  pick;

  // Only a fire seen while a token is in flight counts; anywhere else it is dropped.
  assign fire_acc = (state_q == WAIT) && i_fire;
  assign consume  = fire_acc ? sel_q : '0;
  assign elig     = i_enable & nonzero;
  assign pick     = rr_pick(elig, rr_q);
  assign rr_next  = (sel_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_idx_q + 1'b1;

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_cred
      csel_credit_ctr #(
        .CW    (CREDIT_W_P),
        .CINIT (CREDIT_INIT_P)
      ) u_ctr (
        .clk        (clk),
        .rstn       (rstn),
        .ret_i      (i_credit_ret[g]),
        .consume_i  (consume[g]),
        .count_o    (o_credit[g*CREDIT_W_P +: CREDIT_W_P]),
        .overflow_o (ovf[g]),
        .nonzero_o  (nonzero[g])
      );
    end
  endgenerate

  // Token FSM: pick in IDLE, pulse drive in ARM, hold select in WAIT until fire.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      sel_idx_q  <= '0;
      drv_q      <= 1'b0;
      rr_q       <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      cred_err_q <= 1'b0;
    end else begin
      if (|ovf) cred_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pick.valid) begin
            sel_q     <= pick.onehot;
            sel_idx_q <= pick.idx;
            drv_q     <= 1'b1;
            state_q   <= ARM;
          end
        end
        ARM: begin
          drv_q   <= 1'b0;
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (i_fire) begin
            sel_q   <= '0;
            rr_q    <= rr_next;
            wd_q    <= '0;
            state_q <= IDLE;
          end else if (wd_q != WD_LIMIT) begin
            // Watchdog stops at the limit so it never wraps and re-arms.
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LAST) timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
          drv_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_select   = sel_q;
  assign o_drive_en = drv_q;
  assign o_timeout  = timeout_q;
  assign o_cred_err = cred_err_q;

  // The selector must never see two destinations at once.
  a_sel_onehot0: assert property (@(posedge clk) $onehot0(o_select));

endmodule

// File: tb/tb_cselector6_sched.sv
// tb/tb_cselector6_sched.sv - directed table and sequence bench for cselector6_sched
module tb_cselector6_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  en;
  logic        fire;
  logic [5:0]  ret;
  logic [5:0]  sel;
  logic        drv;
  logic [23:0] cred;
  logic        tmo;
  logic        cerr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] en;
    logic       fire;
    logic [5:0] ret;
    logic [5:0] exp_sel;
    logic       exp_drv;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  cselector6_sched dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_enable     (en),
    .i_fire       (fire),
    .i_credit_ret (ret),
    .o_select     (sel),
    .o_drive_en   (drv),
    .o_credit     (cred),
    .o_timeout    (tmo),
    .o_cred_err   (cerr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] e, input logic f, input logic [5:0] r);
    en   = e;
    fire = f;
    ret  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(6'h00, 1'b0, 6'h00);
    step(6'h00, 1'b0, 6'h00);
    rstn = 1'b1;
  endtask

  // One full token: ARM with drive, first WAIT cycle, fire back to IDLE.
  task automatic run_token(input logic [5:0] e, input logic [5:0] exp_sel, input string tag);
    step(e, 1'b0, 6'h00);
    chk({tag, " arm sel"}, 32'(sel), 32'(exp_sel));
    chk({tag, " arm drv"}, 32'(drv), 32'd1);
    step(e, 1'b0, 6'h00);
    chk({tag, " wait sel"}, 32'(sel), 32'(exp_sel));
    chk({tag, " wait drv"}, 32'(drv), 32'd0);
    step(e, 1'b1, 6'h00);
    chk({tag, " done sel"}, 32'(sel), 32'd0);
  endtask

  function automatic void add(input logic [5:0] e, input logic f, input logic [5:0] r,
                              input logic [5:0] s, input logic d);
    vec_t v;
    v.en = e; v.fire = f; v.ret = r; v.exp_sel = s; v.exp_drv = d;
    tbl.push_back(v);
  endfunction

  initial begin
    rstn = 1'b0;
    en   = '0;
    fire = 1'b0;
    ret  = '0;

    // Full-enable rotation: 01,02,04,08,10,20,01, fire in first WAIT cycle.
    add(6'h3F, 0, 6'h00, 6'h01, 1); add(6'h3F, 0, 6'h00, 6'h01, 0); add(6'h3F, 1, 6'h00, 6'h00, 0);
    add(6'h3F, 0, 6'h00, 6'h02, 1); add(6'h3F, 0, 6'h00, 6'h02, 0); add(6'h3F, 1, 6'h00, 6'h00, 0);
    add(6'h3F, 0, 6'h00, 6'h04, 1); add(6'h3F, 0, 6'h00, 6'h04, 0); add(6'h3F, 1, 6'h00, 6'h00, 0);
    add(6'h3F, 0, 6'h00, 6'h08, 1); add(6'h3F, 0, 6'h00, 6'h08, 0); add(6'h3F, 1, 6'h00, 6'h00, 0);
    add(6'h3F, 0, 6'h00, 6'h10, 1); add(6'h3F, 0, 6'h00, 6'h10, 0); add(6'h3F, 1, 6'h00, 6'h00, 0);
    add(6'h3F, 0, 6'h00, 6'h20, 1); add(6'h3F, 0, 6'h00, 6'h20, 0); add(6'h3F, 1, 6'h00, 6'h00, 0);
    add(6'h3F, 0, 6'h00, 6'h01, 1); add(6'h3F, 0, 6'h00, 6'h01, 0); add(6'h3F, 1, 6'h00, 6'h00, 0);

    do_reset();
    chk("reset sel", 32'(sel), 32'd0);
    chk("reset drv", 32'(drv), 32'd0);
    chk("reset credit", 32'(cred), 32'h444444);
    chk("reset timeout", 32'(tmo), 32'd0);
    chk("reset cred_err", 32'(cerr), 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].fire, tbl[i].ret);
      chk($sformatf("rot[%0d] sel", i), 32'(sel), 32'(tbl[i].exp_sel));
      chk($sformatf("rot[%0d] drv", i), 32'(drv), 32'(tbl[i].exp_drv));
    end
    chk("rot credits", 32'(cred), 32'h333332);

    // Two enabled ports drain to zero credit, then scheduler goes quiet.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      run_token(6'b100100, 6'h04, "alt p2");
      run_token(6'b100100, 6'h20, "alt p5");
    end
    step(6'b100100, 1'b0, 6'h00);
    chk("drained sel", 32'(sel), 32'd0);
    chk("drained drv", 32'(drv), 32'd0);
    step(6'b100100, 1'b0, 6'h00);
    chk("drained sel2", 32'(sel), 32'd0);
    chk("drained credits", 32'(cred), 32'h044044);

    // Credit return revives port 2.
    step(6'b100100, 1'b0, 6'b000100);
    chk("ret p2 credit", 32'(cred[11:8]), 32'd1);
    chk("ret p2 sel idle", 32'(sel), 32'd0);
    run_token(6'b100100, 6'h04, "revive p2");
    chk("revive credit", 32'(cred[11:8]), 32'd0);

    // Watchdog: 254 silent WAIT cycles no timeout, 255th sets it.
    do_reset();
    step(6'h01, 1'b0, 6'h00);
    step(6'h01, 1'b0, 6'h00);
    for (int n = 0; n < 254; n++) step(6'h01, 1'b0, 6'h00);
    chk("wd 254 timeout", 32'(tmo), 32'd0);
    step(6'h01, 1'b0, 6'h00);
    chk("wd 255 timeout", 32'(tmo), 32'd1);
    chk("wd held sel", 32'(sel), 32'h01);
    step(6'h00, 1'b1, 6'h00);
    chk("wd fire sel", 32'(sel), 32'd0);
    chk("wd sticky", 32'(tmo), 32'd1);
    chk("wd credit0", 32'(cred[3:0]), 32'd3);

    // Return and consume together on port 1, then saturate port 0.
    do_reset();
    step(6'h02, 1'b0, 6'h00);
    chk("rc arm sel", 32'(sel), 32'h02);
    step(6'h02, 1'b0, 6'h00);
    step(6'h00, 1'b1, 6'h02);
    chk("rc credit1", 32'(cred[7:4]), 32'd4);
    chk("rc sel", 32'(sel), 32'd0);
    chk("rc no err", 32'(cerr), 32'd0);
    for (int n = 0; n < 11; n++) step(6'h00, 1'b0, 6'h01);
    chk("sat 11 credit0", 32'(cred[3:0]), 32'd15);
    chk("sat 11 err", 32'(cerr), 32'd0);
    step(6'h00, 1'b0, 6'h01);
    chk("sat 12 credit0", 32'(cred[3:0]), 32'd15);
    chk("sat 12 err", 32'(cerr), 32'd1);

    // Reset during WAIT, then a stray fire in IDLE.
    do_reset();
    step(6'h08, 1'b0, 6'h00);
    step(6'h08, 1'b0, 6'h00);
    chk("pre-rst sel", 32'(sel), 32'h08);
    rstn = 1'b0;
    step(6'h00, 1'b0, 6'h00);
    chk("midrst sel", 32'(sel), 32'd0);
    chk("midrst credit", 32'(cred), 32'h444444);
    chk("midrst timeout", 32'(tmo), 32'd0);
    rstn = 1'b1;
    step(6'h00, 1'b1, 6'h00);
    chk("idle fire credit", 32'(cred), 32'h444444);
    chk("idle fire sel", 32'(sel), 32'd0);
    chk("idle fire err", 32'(cerr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
